// File: rtl/divider_pkg.sv
// Shared definitions for the serial restoring divider: FSM state encoding
// and the default operand width.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/borrow_subtractor.sv
// Combinational WIDTH-bit ripple-borrow subtractor (diff = a - b), built from
// a chain of full-subtractor cells; borrow_out is the borrow from the MSB.
module borrow_subtractor
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH + 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  logic chain;

  // The borrow variable is threaded LSB to MSB, one full-subtractor cell per bit.
  always_comb begin
    chain = 1'b0;
    diff  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      diff[i] = a[i] ^ b[i] ^ chain;
      chain   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain);
    end
    borrow_out = chain;
  end

endmodule

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Define DIV_BY_ZERO_CHECK_EN to add the dbz port and the single-cycle divide-by-zero path.
module serial_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV_BY_ZERO_CHECK_EN
  ,
  output logic             dbz
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    count;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB.
  logic [WIDTH-1:0] qsh;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   prem;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   prem_next;
  logic [WIDTH-1:0] q_next;
  logic             borrow;

  always_comb begin
    shifted = (prem << 1) | {{WIDTH{1'b0}}, qsh[WIDTH-1]};
  end

  borrow_subtractor #(
    .WIDTH(WIDTH + 1)
  ) u_sub (
    .a         (shifted),
    .b         ({1'b0, dvs}),
    .diff      (trial),
    .borrow_out(borrow)
  );

  always_comb begin
    prem_next = borrow ? shifted : trial;
    q_next    = {qsh[WIDTH-2:0], ~borrow};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      qsh       <= '0;
      dvs       <= '0;
      prem      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_BY_ZERO_CHECK_EN
      dbz       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
`ifdef DIV_BY_ZERO_CHECK_EN
            if (divisor == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
              dbz       <= 1'b1;
            end else
`endif
            begin
              state <= RUN;
              busy  <= 1'b1;
              count <= '0;
              qsh   <= dividend;
              dvs   <= divisor;
              prem  <= '0;
            end
          end
        end
        RUN: begin
          qsh   <= q_next;
          prem  <= prem_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= prem_next[WIDTH-1:0];
`ifdef DIV_BY_ZERO_CHECK_EN
            dbz       <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_divider.md
SERIAL_DIVIDER -- requirements
Module: serial_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a division.
REQ-005 The block SHALL have port dividend, input, WIDTH bits, unsigned numerator, sampled only when start is accepted.
REQ-006 The block SHALL have port divisor, input, WIDTH bits, unsigned denominator, sampled only when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit, high while a division is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking valid results.
REQ-009 The block SHALL have port quotient, output, WIDTH bits, the result quotient.
REQ-010 The block SHALL have port remainder, output, WIDTH bits, the result remainder.
REQ-011 The block SHALL have port dbz, output, 1 bit, the divide-by-zero flag; it exists only when DIV_BY_ZERO_CHECK_EN is defined.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 The FSM SHALL accept start only in IDLE or DONE, capturing dividend and divisor and clearing the partial remainder.
REQ-014 The FSM SHALL ignore start while in RUN, with no restart and no change to the captured operands.
REQ-015 RUN SHALL execute exactly WIDTH restoring iterations, one per cycle, MSB first.
REQ-016 Each RUN iteration SHALL shift the partial remainder left by one, bringing in the next dividend bit, and then compute trial = partial remainder - divisor.
REQ-017 When the trial subtraction has no borrow, each RUN iteration SHALL take trial as the new partial remainder and set the quotient bit to 1; otherwise it SHALL keep the partial remainder and set the quotient bit to 0.
REQ-018 The partial remainder SHALL be WIDTH+1 bits wide internally so that the subtraction never overflows; the remainder output is its low WIDTH bits.
REQ-019 Timing: if start is sampled at edge N, busy SHALL be 1 from cycle N+1 through N+WIDTH, and done SHALL be 1 in cycle N+WIDTH+1 only.
REQ-020 quotient and remainder SHALL be updated only on the cycle done rises, and SHALL hold until the next done or until reset.
REQ-021 DONE SHALL last one cycle, then go to IDLE; if start is high in DONE, the block SHALL go directly to RUN with no idle cycle.
REQ-022 The block SHALL guarantee the invariant dividend = quotient*divisor + remainder with remainder < divisor for any divisor other than 0.
REQ-023 For divisor 0 with no check compiled in, the natural algorithm result SHALL be produced: quotient all ones, remainder = dividend, latency unchanged.

Reset
REQ-024 While rst=1 at an edge, the block SHALL enter IDLE and drive busy=0, done=0, quotient=0, remainder=0 and dbz=0.
REQ-025 Reset asserted during RUN SHALL abort the operation, with no done pulse and no result update.
REQ-026 rst SHALL take priority over start in the same cycle.

Configuration
REQ-027 With DIV_BY_ZERO_CHECK_EN defined, a start with divisor 0 SHALL skip RUN, produce done in cycle N+1 with quotient all ones, remainder = dividend and dbz=1, and busy SHALL stay 0.
REQ-028 With DIV_BY_ZERO_CHECK_EN defined, dbz SHALL hold with the results and clear on the next done that has a nonzero divisor.
REQ-029 Without DIV_BY_ZERO_CHECK_EN, the dbz port and its logic SHALL be absent, and divisor 0 SHALL follow REQ-023.

Structure
REQ-030 A shared package divider_pkg SHALL hold the FSM state enumeration (IDLE, RUN, DONE) and the default width constant.
REQ-031 A single sub-module, borrow_subtractor, SHALL implement the trial subtraction: a WIDTH+1 ripple chain of full-subtractor cells with outputs difference and borrow-out.
REQ-032 The sub-module SHALL be purely combinational, with all registers in serial_divider.

Verification
REQ-033 The bench SHALL cover: WIDTH=8, start with 100 / 7 -> done at N+9 with quotient=14, remainder=2, busy high for exactly 8 cycles.
REQ-034 The bench SHALL cover: 255 / 1 -> quotient=255, remainder=0; and 5 / 10 -> quotient=0, remainder=5.
REQ-035 The bench SHALL cover: 200 / 0 -> quotient=255 and remainder=200; with the macro, done at N+1 and dbz=1; without it, done at N+9.
REQ-036 The bench SHALL cover: 100 / 7 started, then start with 50 / 5 pulsed at N+3 -> the second request is ignored and the result is 14 r 2.
REQ-037 The bench SHALL cover: 100 / 7 started with rst at N+4 -> no done pulse, outputs 0, and a fresh 9 / 3 afterwards gives 3 r 0.
REQ-038 The bench SHALL cover: a back-to-back start held high in DONE -> the second result follows after WIDTH+1 cycles with no idle gap; plus a random sweep checking REQ-022.
